serial_port_m1: RTL and testbench
=================================

// Module: serial_port_m1
// PURPOSE
//   8051 serial port, mode 1 (8-bit UART: 1 start, 8 data LSB first, 1 stop).
//   Consumes the Timer overflow pulse as its baud source and turns it into TX/RX
//   frames. Presents SBUF/SCON-style strobes (ti_set/ri_set) to the SFR block.
//   Sits between Timer 1 (t_ovf) and the chip pins txd/rxd.
// PARAMETERS
//   OVS      16   sample ticks per bit; fixed by 8051 mode-1 definition
//   SYNC_FF  2    rxd synchroniser depth
// PORTS
//   clk          in   1  system clock
//   rst_n        in   1  synchronous reset, active-low
//   t_ovf        in   1  Timer overflow, one clk-cycle pulse per overflow
//   smod         in   1  PCON.SMOD: 1 = tick on every t_ovf, 0 = every 2nd t_ovf
//   ren          in   1  SCON.REN receive enable
//   ri           in   1  current SCON.RI; if 1 at stop bit, frame is discarded
//   sbuf_wr      in   1  one-cycle write strobe to SBUF (starts TX)
//   sbuf_wdata   in   8  byte to transmit
//   rxd          in   1  serial input pin, asynchronous
//   txd          out  1  serial output pin
//   sbuf_rdata   out  8  last received byte
//   rb8          out  1  received stop bit
//   ti_set       out  1  one-cycle pulse: set SCON.TI
//   ri_set       out  1  one-cycle pulse: set SCON.RI
//   tx_busy      out  1  high from accepted sbuf_wr to end of stop bit
// BEHAVIOUR
//   Reset: txd=1, sbuf_rdata=0, rb8=0, ti_set=0, ri_set=0, tx_busy=0; both FSMs IDLE,
//     divider and sample counters cleared. Reset mid-frame aborts; no strobes issued.
//   Tick: tick16 = t_ovf & (smod | div_ff); div_ff toggles on each t_ovf, cleared on reset.
//     One bit time = 16 tick16s (SMOD=0 -> 32 overflows, SMOD=1 -> 16 overflows).
//   TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//     IDLE: sbuf_wr latches sbuf_wdata, tx_busy=1 next cycle, -> START. txd changes only
//       on tick16 (start bit begins at first tick16 after sbuf_wr).
//     Each state holds 16 tick16s; DATA shifts bit0..bit7 on txd; STOP drives txd=1.
//     ti_set pulses one cycle on the tick16 that enters STOP. tx_busy drops when STOP ends.
//     sbuf_wr while tx_busy=1: ignored, no state change.
//   RX FSM: IDLE -> START -> DATA -> STOP -> IDLE; rxd passes SYNC_FF flops first.
//     IDLE (ren=1): 1->0 of synced rxd sampled on tick16 -> START, sample counter=0.
//     Each bit: samples at counts 7,8,9; bit value = majority of 3.
//     START majority=1 -> false start, back to IDLE, no strobe.
//     DATA: 8 bits into shift register, LSB first.
//     STOP at count 9: if ri==0 and stop majority==1 -> sbuf_rdata<=shift, rb8<=1,
//       ri_set pulses one cycle; otherwise frame dropped, outputs unchanged.
//     Return to IDLE right after stop-bit decision (count 9), ready for next start edge.
//     ren=0 at any time: RX -> IDLE immediately, partial frame discarded.
//   TX and RX are fully independent; simultaneous ti_set and ri_set allowed.
//   All counters are 4-bit (sample) and 3-bit (bit index), wrap naturally; no overflow states.
// STRUCTURE
//   Shared package serial_pkg: FSM state encodings (S_IDLE,S_START,S_DATA,S_STOP),
//     OVS=16, sample-point constants SMP_A=7, SMP_B=8, SMP_C=9.
//   Sub-module serial_baud_tick: t_ovf + smod -> tick16 (div_ff). TX/RX FSMs inline.
// TESTING (t_ovf every 4 clk unless stated)
//   1 smod=1, sbuf_wr 0xA5 -> txd 0,1,0,1,0,0,1,0,1,1 each 64 clk; ti_set 1 pulse at
//     stop start; tx_busy low after 640 clk of frame.
//   2 smod=0, same write -> each bit 128 clk; frame 1280 clk.
//   3 loopback rxd=txd, ren=1, ri=0, send 0x3C -> sbuf_rdata=0x3C, rb8=1, one ri_set.
//   4 rxd low for 2 tick16s then high -> false start, no ri_set, RX back to IDLE.
//   5 ri=1 during receive of 0x55 -> no ri_set, sbuf_rdata unchanged; ren=0 -> ignores rxd.
//   6 rst_n low mid-TX data bit 4 -> txd=1 next clk, no ti_set; sbuf_wr during busy ignored.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the 8051 mode-1 serial port.
// FSM encodings, oversampling and sample-point constants.
package serial_pkg;

    localparam int OVS = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [3:0] SMP_A = 4'd7;
    localparam logic [3:0] SMP_B = 4'd8;
    localparam logic [3:0] SMP_C = 4'd9;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/serial_baud_tick.sv
// Turns timer overflow pulses into the 16x oversampling tick.
// Without SMOD every second overflow is swallowed.
module serial_baud_tick (
    input  logic clk,
    input  logic rst_n,
    input  logic t_ovf_i,
    input  logic smod_i,
    output logic tick16_o
);

    logic div_q;

    // divide-by-two flop, toggles on every overflow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= 1'b0;
        end else if (t_ovf_i) begin
            div_q <= ~div_q;
        end
    end

    assign tick16_o = t_ovf_i & (smod_i | div_q);

endmodule

// File: rtl/serial_port_m1.sv
// 8051 serial port, mode 1: 8N1 UART driven by timer overflow.
// Independent TX and RX FSMs; RX majority-votes samples 7/8/9.
module serial_port_m1 #(
    parameter int OVS     = serial_pkg::OVS,
    parameter int SYNC_FF = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       t_ovf,
    input  logic       smod,
    input  logic       ren,
    input  logic       ri,
    input  logic       sbuf_wr,
    input  logic [7:0] sbuf_wdata,
    input  logic       rxd,
    output logic       txd,
    output logic [7:0] sbuf_rdata,
    output logic       rb8,
    output logic       ti_set,
    output logic       ri_set,
    output logic       tx_busy
);

    import serial_pkg::*;

    localparam logic [3:0] CNT_LAST = 4'(OVS - 1);

    logic tick16;

    serial_baud_tick u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .t_ovf_i  (t_ovf),
        .smod_i   (smod),
        .tick16_o (tick16)
    );

    // ---------------- transmitter ----------------
    logic [1:0] tx_st_q, tx_st_d;
    logic [3:0] tx_cnt_q, tx_cnt_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    logic       tx_arm_q, tx_arm_d;
    logic       txd_q, txd_d;
    logic       busy_q, busy_d;
    logic       ti_q, ti_d;

    // TX next state; arm flag delays the start bit to the next tick
    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = tx_cnt_q;
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        tx_arm_d = tx_arm_q;
        txd_d    = txd_q;
        busy_d   = busy_q;
        ti_d     = 1'b0;
        unique case (tx_st_q)
            S_IDLE: begin
                if (sbuf_wr) begin
                    tx_sh_d  = sbuf_wdata;
                    busy_d   = 1'b1;
                    tx_arm_d = 1'b1;
                    tx_st_d  = S_START;
                end
            end
            S_START: begin
                if (tick16) begin
                    if (tx_arm_q) begin
                        txd_d    = 1'b0;
                        tx_arm_d = 1'b0;
                        tx_cnt_d = 4'd0;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 4'd1;
                        if (tx_cnt_q == CNT_LAST) begin
                            tx_st_d  = S_DATA;
                            tx_bit_d = 3'd0;
                            txd_d    = tx_sh_q[0];
                        end
                    end
                end
            end
            S_DATA: begin
                if (tick16) begin
                    tx_cnt_d = tx_cnt_q + 4'd1;
                    if (tx_cnt_q == CNT_LAST) begin
                        if (tx_bit_q == 3'd7) begin
                            tx_st_d = S_STOP;
                            txd_d   = 1'b1;
                            ti_d    = 1'b1;
                        end else begin
                            tx_bit_d = tx_bit_q + 3'd1;
                            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                            txd_d    = tx_sh_q[1];
                        end
                    end
                end
            end
            S_STOP: begin
                if (tick16) begin
                    tx_cnt_d = tx_cnt_q + 4'd1;
                    if (tx_cnt_q == CNT_LAST) begin
                        tx_st_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: tx_st_d = S_IDLE;
        endcase
    end

    // TX state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_st_q  <= S_IDLE;
            tx_cnt_q <= 4'd0;
            tx_bit_q <= 3'd0;
            tx_sh_q  <= 8'd0;
            tx_arm_q <= 1'b0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            ti_q     <= 1'b0;
        end else begin
            tx_st_q  <= tx_st_d;
            tx_cnt_q <= tx_cnt_d;
            tx_bit_q <= tx_bit_d;
            tx_sh_q  <= tx_sh_d;
            tx_arm_q <= tx_arm_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            ti_q     <= ti_d;
        end
    end

    assign txd     = txd_q;
    assign tx_busy = busy_q;
    assign ti_set  = ti_q;

    // ---------------- receiver ----------------
    logic [SYNC_FF-1:0] rx_sync_q;
    logic               rx_in;
    logic               rx_last_q, rx_last_d;
    logic [1:0]         rx_st_q, rx_st_d;
    logic [3:0]         rx_cnt_q, rx_cnt_d;
    logic [2:0]         rx_bit_q, rx_bit_d;
    logic [7:0]         rx_sh_q, rx_sh_d;
    logic [1:0]         rx_smp_q, rx_smp_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               rb8_q, rb8_d;
    logic               ri_q, ri_d;
    logic               maj;

    assign rx_in = rx_sync_q[SYNC_FF-1];
    assign maj   = maj3(rx_smp_q[0], rx_smp_q[1], rx_in);

    // metastability synchroniser for the asynchronous pin
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_sync_q <= '1;
        end else begin
            rx_sync_q <= {rx_sync_q[SYNC_FF-2:0], rxd};
        end
    end

    // RX next state; vote is taken at SMP_C with the live sample
    always_comb begin
        rx_last_d = rx_last_q;
        rx_st_d   = rx_st_q;
        rx_cnt_d  = rx_cnt_q;
        rx_bit_d  = rx_bit_q;
        rx_sh_d   = rx_sh_q;
        rx_smp_d  = rx_smp_q;
        rdata_d   = rdata_q;
        rb8_d     = rb8_q;
        ri_d      = 1'b0;
        if (tick16) begin
            rx_last_d = rx_in;
        end
        if (!ren) begin
            rx_st_d = S_IDLE;
        end else if (tick16) begin
            if (rx_st_q != S_IDLE) begin
                rx_cnt_d = rx_cnt_q + 4'd1;
                if (rx_cnt_q == SMP_A) rx_smp_d[0] = rx_in;
                if (rx_cnt_q == SMP_B) rx_smp_d[1] = rx_in;
            end
            unique case (rx_st_q)
                S_IDLE: begin
                    if (rx_last_q && !rx_in) begin
                        rx_st_d  = S_START;
                        rx_cnt_d = 4'd0;
                    end
                end
                S_START: begin
                    if (rx_cnt_q == SMP_C && maj) begin
                        rx_st_d = S_IDLE;
                    end else if (rx_cnt_q == CNT_LAST) begin
                        rx_st_d  = S_DATA;
                        rx_bit_d = 3'd0;
                    end
                end
                S_DATA: begin
                    if (rx_cnt_q == SMP_C) begin
                        rx_sh_d = {maj, rx_sh_q[7:1]};
                    end
                    if (rx_cnt_q == CNT_LAST) begin
                        if (rx_bit_q == 3'd7) begin
                            rx_st_d = S_STOP;
                        end else begin
                            rx_bit_d = rx_bit_q + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (rx_cnt_q == SMP_C) begin
                        rx_st_d = S_IDLE;
                        if (!ri && maj) begin
                            rdata_d = rx_sh_q;
                            rb8_d   = maj;
                            ri_d    = 1'b1;
                        end
                    end
                end
                default: rx_st_d = S_IDLE;
            endcase
        end
    end

    // RX state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_last_q <= 1'b1;
            rx_st_q   <= S_IDLE;
            rx_cnt_q  <= 4'd0;
            rx_bit_q  <= 3'd0;
            rx_sh_q   <= 8'd0;
            rx_smp_q  <= 2'b11;
            rdata_q   <= 8'd0;
            rb8_q     <= 1'b0;
            ri_q      <= 1'b0;
        end else begin
            rx_last_q <= rx_last_d;
            rx_st_q   <= rx_st_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
            rx_smp_q  <= rx_smp_d;
            rdata_q   <= rdata_d;
            rb8_q     <= rb8_d;
            ri_q      <= ri_d;
        end
    end

    assign sbuf_rdata = rdata_q;
    assign rb8        = rb8_q;
    assign ri_set     = ri_q;

endmodule

// File: tb/tb_serial_port_m1.sv
// Directed bench for serial_port_m1: TX timing, loopback RX,
// false start, RI/REN gating and mid-frame reset.
module tb_serial_port_m1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       t_ovf = 1'b0;
    logic       smod;
    logic       ren;
    logic       ri;
    logic       sbuf_wr;
    logic [7:0] sbuf_wdata;
    wire        rxd;
    logic       txd;
    logic [7:0] sbuf_rdata;
    logic       rb8;
    logic       ti_set;
    logic       ri_set;
    logic       tx_busy;

    logic       loop = 1'b0;
    logic       rxd_man = 1'b1;
    logic [1:0] ovf_ph = 2'd0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ti_cnt  = 0;
    int ti_cyc  = 0;
    int ri_cnt  = 0;
    int k;

    assign rxd = loop ? txd : rxd_man;

    serial_port_m1 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .t_ovf      (t_ovf),
        .smod       (smod),
        .ren        (ren),
        .ri         (ri),
        .sbuf_wr    (sbuf_wr),
        .sbuf_wdata (sbuf_wdata),
        .rxd        (rxd),
        .txd        (txd),
        .sbuf_rdata (sbuf_rdata),
        .rb8        (rb8),
        .ti_set     (ti_set),
        .ri_set     (ri_set),
        .tx_busy    (tx_busy)
    );

    always #5 clk = ~clk;

    // one t_ovf pulse every 4 clocks
    always @(negedge clk) begin
        ovf_ph = ovf_ph + 2'd1;
        t_ovf  = (ovf_ph == 2'd0);
    end

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (ti_set === 1'b1) begin
            ti_cnt = ti_cnt + 1;
            ti_cyc = cyc;
        end
        if (ri_set === 1'b1) ri_cnt = ri_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_start(input string nm);
        int n;
        n = 0;
        while (txd !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " start_seen"}, 32'(n < 400), 32'd1);
    endtask

    task automatic tx_frame(input logic [7:0] d, input int p, input string nm);
        int t0;
        ti_cnt = 0;
        sbuf_wdata = d;
        sbuf_wr = 1'b1;
        @(negedge clk);
        sbuf_wr = 1'b0;
        chk({nm, " busy_set"}, 32'(tx_busy), 32'd1);
        wait_start(nm);
        t0 = cyc;
        repeat (p / 2) @(negedge clk);
        chk({nm, " start_bit"}, 32'(txd), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (p) @(negedge clk);
            chk({nm, " data_bit"}, 32'(txd), 32'(d[i]));
        end
        repeat (p) @(negedge clk);
        chk({nm, " stop_bit"}, 32'(txd), 32'd1);
        chk({nm, " ti_count"}, 32'(ti_cnt), 32'd1);
        chk({nm, " ti_time"}, 32'(ti_cyc - t0), 32'(9 * p));
        repeat (p / 2 - 2) @(negedge clk);
        chk({nm, " busy_end_m"}, 32'(tx_busy), 32'd1);
        repeat (2) @(negedge clk);
        chk({nm, " busy_end_p"}, 32'(tx_busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        smod = 1'b1;
        ren = 1'b0;
        ri = 1'b0;
        sbuf_wr = 1'b0;
        sbuf_wdata = 8'h00;
        repeat (5) @(negedge clk);
        chk("rst txd", 32'(txd), 32'd1);
        chk("rst busy", 32'(tx_busy), 32'd0);
        chk("rst rdata", 32'(sbuf_rdata), 32'd0);
        chk("rst rb8", 32'(rb8), 32'd0);
        chk("rst ti", 32'(ti_set), 32'd0);
        chk("rst ri", 32'(ri_set), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        smod = 1'b1;
        tx_frame(8'hA5, 64, "t1");
        smod = 1'b0;
        tx_frame(8'hA5, 128, "t2");
        smod = 1'b1;

        ren = 1'b1;
        loop = 1'b1;
        ri_cnt = 0;
        tx_frame(8'h3C, 64, "t3");
        repeat (20) @(negedge clk);
        chk("t3 rdata", 32'(sbuf_rdata), 32'h3C);
        chk("t3 rb8", 32'(rb8), 32'd1);
        chk("t3 ri_count", 32'(ri_cnt), 32'd1);

        loop = 1'b0;
        ri_cnt = 0;
        rxd_man = 1'b0;
        repeat (8) @(negedge clk);
        rxd_man = 1'b1;
        repeat (200) @(negedge clk);
        chk("t4 ri_count", 32'(ri_cnt), 32'd0);
        chk("t4 rdata", 32'(sbuf_rdata), 32'h3C);

        loop = 1'b1;
        ri = 1'b1;
        ri_cnt = 0;
        tx_frame(8'h55, 64, "t5a");
        repeat (20) @(negedge clk);
        chk("t5 ri_hold count", 32'(ri_cnt), 32'd0);
        chk("t5 ri_hold rdata", 32'(sbuf_rdata), 32'h3C);
        ri = 1'b0;
        ren = 1'b0;
        tx_frame(8'hF0, 64, "t5b");
        repeat (20) @(negedge clk);
        chk("t5 ren0 count", 32'(ri_cnt), 32'd0);
        chk("t5 ren0 rdata", 32'(sbuf_rdata), 32'h3C);
        ren = 1'b1;
        tx_frame(8'h55, 64, "t5c");
        repeat (20) @(negedge clk);
        chk("t5 rx rdata", 32'(sbuf_rdata), 32'h55);
        chk("t5 rx count", 32'(ri_cnt), 32'd1);

        loop = 1'b0;
        ti_cnt = 0;
        sbuf_wdata = 8'h86;
        sbuf_wr = 1'b1;
        @(negedge clk);
        sbuf_wr = 1'b0;
        wait_start("t6");
        repeat (32) @(negedge clk);
        sbuf_wdata = 8'h00;
        sbuf_wr = 1'b1;
        @(negedge clk);
        sbuf_wr = 1'b0;
        chk("t6 busy", 32'(tx_busy), 32'd1);
        repeat (63) @(negedge clk);
        chk("t6 bit0", 32'(txd), 32'd0);
        repeat (64) @(negedge clk);
        chk("t6 bit1", 32'(txd), 32'd1);
        repeat (64) @(negedge clk);
        chk("t6 bit2", 32'(txd), 32'd1);
        repeat (128) @(negedge clk);
        chk("t6 bit4", 32'(txd), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6 rst txd", 32'(txd), 32'd1);
        chk("t6 rst busy", 32'(tx_busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        chk("t6 no ti", 32'(ti_cnt), 32'd0);
        chk("t6 idle txd", 32'(txd), 32'd1);
        chk("t6 idle busy", 32'(tx_busy), 32'd0);
        chk("t6 rdata", 32'(sbuf_rdata), 32'd0);
        chk("t6 rb8", 32'(rb8), 32'd0);

        k = n_fail;
        $display("[TB] %0d tests run, %0d failed", n_tests, k);
        $finish;
    end

endmodule
